// File: rtl/counter_frequency_div_100_pkg.sv
// Shared prescaler definitions: default ratio and counter width helper.
// Reused by the seconds/minutes counters of the microwave controller.
package counter_frequency_div_100_pkg;

  localparam int DIV_100 = 100;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/counter_frequency_div_100_mod_counter.sv
// Modulo-MOD up counter with async reset and combinational wrap flag.
// Any value at or above MOD-1 wraps to 0 on the next edge.
module mod_counter
  import counter_frequency_div_100_pkg::*;
#(
  parameter int MOD = DIV_100,
  localparam int CW = cnt_width(MOD)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  always_comb begin
    wrap    = (count_q >= LAST);
    count_d = wrap ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_frequency_div_100.sv
// Prescaler: f_clk/DIV square wave, period tick and live count.
// All outputs are registered; out follows the next count value.
module counter_frequency_div_100
  import counter_frequency_div_100_pkg::*;
#(
  parameter int DIV = DIV_100,
  localparam int CW = cnt_width(DIV)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          out,
  output logic          tick,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic [CW-1:0] cnt;
  logic          wrap;
  logic [CW-1:0] cnt_nxt;
  logic          out_d;
  logic          out_q;
  logic          tick_d;
  logic          tick_q;

  mod_counter #(
    .MOD(DIV)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .count(cnt),
    .wrap (wrap)
  );

  // Same next value the counter loads, so out lines up with count.
  always_comb begin
    cnt_nxt = wrap ? '0 : cnt + CW'(1);
    out_d   = (cnt_nxt >= HALF);
    tick_d  = wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out   = out_q;
  assign tick  = tick_q;
  assign count = cnt;

endmodule

// File: tb/tb_counter_frequency_div_100.sv
// Randomized bench for the prescaler at DIV = 100, 7 and 2.
// Reference: edges since reset release, reduced modulo DIV.
module tb_counter_frequency_div_100;

  logic       clk = 1'b0;
  logic       rst;
  logic       o100, t100;
  logic [6:0] c100;
  logic       o7, t7;
  logic [2:0] c7;
  logic       o2, t2;
  logic [0:0] c2;

  int n_chk = 0;
  int n_err = 0;
  int n = 0;

  always #5 clk = ~clk;

  counter_frequency_div_100 #(.DIV(100)) u_d100 (
    .clk(clk), .reset(rst), .out(o100), .tick(t100), .count(c100)
  );
  counter_frequency_div_100 #(.DIV(7)) u_d7 (
    .clk(clk), .reset(rst), .out(o7), .tick(t7), .count(c7)
  );
  counter_frequency_div_100 #(.DIV(2)) u_d2 (
    .clk(clk), .reset(rst), .out(o2), .tick(t2), .count(c2)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d (t=%0t n=%0d)",
               tag, obs, exp, $time, n);
    end
  endtask

  task automatic chk_div(input string nm, input int d,
                         input int c, input int o, input int t);
    int m;
    m = n % d;
    chk({nm, "_count"}, c, m);
    chk({nm, "_out"}, o, (m >= d / 2) ? 1 : 0);
    chk({nm, "_tick"}, t, (n > 0 && m == 0) ? 1 : 0);
    chk({nm, "_range"}, (c < d) ? 1 : 0, 1);
  endtask

  task automatic check_all();
    chk_div("d100", 100, int'(c100), int'(o100), int'(t100));
    chk_div("d7", 7, int'(c7), int'(o7), int'(t7));
    chk_div("d2", 2, int'(c2), int'(o2), int'(t2));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_c100"}, int'(c100), 0);
    chk({tag, "_o100"}, int'(o100), 0);
    chk({tag, "_t100"}, int'(t100), 0);
    chk({tag, "_c7"}, int'(c7), 0);
    chk({tag, "_o7"}, int'(o7), 0);
    chk({tag, "_t7"}, int'(t7), 0);
    chk({tag, "_c2"}, int'(c2), 0);
    chk({tag, "_o2"}, int'(o2), 0);
  endtask

  initial begin
    int rises, falls, ticks, hi_run, lo_run;
    bit prev, seen_fall, found;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst_hold");
    #2 rst = 1'b0;
    #1 check_zero("rst_rel");

    rises = 0; falls = 0; ticks = 0;
    hi_run = 0; lo_run = 0;
    prev = 1'b0; seen_fall = 1'b0;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      check_all();
      if (i == 49) chk("edge49_out", int'(o100), 0);
      if (i == 50) chk("edge50_out", int'(o100), 1);
      if (o100 && !prev) begin
        if (seen_fall) chk("lo_len", lo_run, 50);
        rises++;
        hi_run = 0;
      end
      if (!o100 && prev) begin
        chk("hi_len", hi_run, 50);
        falls++;
        seen_fall = 1'b1;
        lo_run = 0;
      end
      if (o100) hi_run++;
      else      lo_run++;
      if (t100) ticks++;
      prev = o100;
    end
    chk("rises", rises, 50);
    chk("falls", falls, 50);
    chk("ticks", ticks, 50);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      check_all();
      if (n % 100 == 73) found = 1'b1;
    end
    chk("find73", int'(found), 1);
    chk("at73_out", int'(o100), 1);
    chk("at73_cnt", int'(c100), 73);
    #2 rst = 1'b1;
    #1 check_zero("mid_rst");
    @(negedge clk);
    check_all();
    #2 rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      check_all();
    end

    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      check_all();
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 check_zero("rnd_rst");
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check_all();
        end
        #2 rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
